// File: rtl/weight_filter_pkg.sv
// Shared widths, default tuning values and state encoding for the weight filter.
// Also holds a small absolute-difference helper used by the settle detector.
package weight_filter_pkg;

  localparam int WEIGHT_W       = 16;
  localparam int AVG_LOG2_DEF   = 2;
  localparam int STABLE_TOL_DEF = 2;
  localparam int STABLE_CNT_DEF = 3;
  localparam int MAX_WEIGHT_DEF = 1000;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } wf_state_t;

  function automatic logic [WEIGHT_W-1:0] abs_diff(input logic [WEIGHT_W-1:0] a,
                                                   input logic [WEIGHT_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/weight_filter_ring_buf.sv
// Register ring holding the last 2^DEPTH_LOG2 samples of the moving-average window.
// old_data is the sample about to be overwritten, so the caller can subtract it from the sum.
module weight_filter_ring_buf #(
  parameter int DEPTH_LOG2 = 2,
  parameter int DATA_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] old_data,
  output logic              last
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0]     slot_reg [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          slot_reg[gi] <= '0;
        end else if (wr_en && (wr_ptr_reg == DEPTH_LOG2'(gi))) begin
          slot_reg[gi] <= wr_data;
        end
      end
    end
  endgenerate

  // Power-of-two depth: the pointer wraps naturally on overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
    end else if (wr_en) begin
      wr_ptr_reg <= wr_ptr_reg + DEPTH_LOG2'(1);
    end
  end

  assign old_data = slot_reg[wr_ptr_reg];
  assign last     = (wr_ptr_reg == '1);

endmodule

// File: rtl/weight_filter.sv
// Moving-average filter for raw scale codes with tare, clamp, settle and overload flags.
// Two-stage pipeline: S1 updates the window sum, S2 registers the net value and flags.
module weight_filter
  import weight_filter_pkg::*;
#(
  parameter int AVG_LOG2   = AVG_LOG2_DEF,
  parameter int STABLE_TOL = STABLE_TOL_DEF,
  parameter int STABLE_CNT = STABLE_CNT_DEF,
  parameter int MAX_WEIGHT = MAX_WEIGHT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WEIGHT_W-1:0] hx_in,
  input  logic                hx_vld,
  input  logic                tare_req,
  output logic [WEIGHT_W-1:0] net_out,
  output logic                out_vld,
  output logic                stable,
  output logic                overload,
  output logic                under_tare
);

  localparam int SUM_W = WEIGHT_W + AVG_LOG2;
  localparam int CNT_W = $clog2(STABLE_CNT + 1);

  wf_state_t           state_reg;
  logic [SUM_W-1:0]    sum_reg;
  logic [WEIGHT_W-1:0] tare_reg;
  logic [WEIGHT_W-1:0] prev_avg_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                tare_pend_reg;
  logic                first_reg;
  logic                s2_pend_reg;

  logic [WEIGHT_W-1:0] old_data;
  logic                buf_last;
  logic                s1_en;
  logic                s2_run;
  logic [WEIGHT_W-1:0] avg;
  logic [WEIGHT_W-1:0] net_diff;
  logic [CNT_W-1:0]    cnt_next;

  // A sample arriving while the previous one is still in S2 is dropped.
  assign s1_en  = hx_vld && !s2_pend_reg;
  assign s2_run = s2_pend_reg && (state_reg == ST_RUN);

  weight_filter_ring_buf #(
    .DEPTH_LOG2 (AVG_LOG2),
    .DATA_W     (WEIGHT_W)
  ) u_ring_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (s1_en),
    .wr_data  (hx_in),
    .old_data (old_data),
    .last     (buf_last)
  );

  always_comb begin
    avg      = WEIGHT_W'(sum_reg >> AVG_LOG2);
    net_diff = avg - tare_reg;
    cnt_next = '0;
    if (!first_reg && (abs_diff(avg, prev_avg_reg) <= WEIGHT_W'(STABLE_TOL))) begin
      cnt_next = (cnt_reg == CNT_W'(STABLE_CNT)) ? cnt_reg : cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_FILL;
      sum_reg       <= '0;
      tare_reg      <= '0;
      prev_avg_reg  <= '0;
      cnt_reg       <= '0;
      tare_pend_reg <= 1'b0;
      first_reg     <= 1'b1;
      s2_pend_reg   <= 1'b0;
      net_out       <= '0;
      out_vld       <= 1'b0;
      stable        <= 1'b0;
      overload      <= 1'b0;
      under_tare    <= 1'b0;
    end else begin
      s2_pend_reg <= s1_en;
      out_vld     <= s2_run;

      if (s1_en) begin
        sum_reg <= sum_reg + SUM_W'(hx_in) - SUM_W'(old_data);
        if (state_reg == ST_FILL && buf_last) begin
          state_reg <= ST_RUN;
        end
      end

      // A request landing on the S2 edge stays pending for the next output.
      tare_pend_reg <= tare_req || (tare_pend_reg && !s2_run);

      if (s2_run) begin
        prev_avg_reg <= avg;
        first_reg    <= 1'b0;
        if (tare_pend_reg) begin
          tare_reg   <= avg;
          net_out    <= '0;
          under_tare <= 1'b0;
          overload   <= 1'b0;
          cnt_reg    <= '0;
          stable     <= 1'b0;
        end else begin
          if (avg >= tare_reg) begin
            net_out    <= net_diff;
            under_tare <= 1'b0;
            overload   <= (net_diff > WEIGHT_W'(MAX_WEIGHT));
          end else begin
            net_out    <= '0;
            under_tare <= 1'b1;
            overload   <= 1'b0;
          end
          cnt_reg <= cnt_next;
          stable  <= (cnt_next == CNT_W'(STABLE_CNT));
        end
      end
    end
  end

endmodule

// File: tb/tb_weight_filter.sv
// Directed-vector bench for weight_filter: stimulus pushes expected outputs into a queue,
// an independent monitor pops and compares each out_vld pulse.
module tb_weight_filter;

  logic        clk;
  logic        rst;
  logic [15:0] hx_in;
  logic        hx_vld;
  logic        tare_req;
  logic [15:0] net_out;
  logic        out_vld;
  logic        stable;
  logic        overload;
  logic        under_tare;

  typedef struct {
    int          id;
    logic [15:0] net;
    logic        st;
    logic        ov;
    logic        ut;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec   = 0;
  int   n_bad   = 0;
  int   vec_id  = 0;
  int   n_out   = 0;
  int   since_vld = 100;

  weight_filter dut (
    .clk        (clk),
    .rst        (rst),
    .hx_in      (hx_in),
    .hx_vld     (hx_vld),
    .tare_req   (tare_req),
    .net_out    (net_out),
    .out_vld    (out_vld),
    .stable     (stable),
    .overload   (overload),
    .under_tare (under_tare)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Samples must be at least 3 cycles apart.
  always @(posedge clk) begin
    if (hx_vld) begin
      assert (since_vld >= 3) else $error("hx_vld spacing violated: %0d cycles", since_vld);
      since_vld = 0;
    end else if (since_vld < 100) begin
      since_vld = since_vld + 1;
    end
  end

  // Monitor: every output pulse is matched against the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_vld) begin
      n_out = n_out + 1;
      n_vec = n_vec + 1;
      if (exp_q.size() == 0) begin
        n_bad = n_bad + 1;
        $display("FAIL unexpected_out: got net=%0d st=%0b ov=%0b ut=%0b, required no out_vld",
                 net_out, stable, overload, under_tare);
      end else begin
        e = exp_q.pop_front();
        if (net_out !== e.net || stable !== e.st || overload !== e.ov || under_tare !== e.ut) begin
          n_bad = n_bad + 1;
          $display("FAIL vec%0d: got net=%0d st=%0b ov=%0b ut=%0b, required net=%0d st=%0b ov=%0b ut=%0b",
                   e.id, net_out, stable, overload, under_tare, e.net, e.st, e.ov, e.ut);
        end else begin
          $display("vec%0d ok: net=%0d st=%0b ov=%0b ut=%0b",
                   e.id, net_out, stable, overload, under_tare);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    hx_vld = 1'b0;
    tare_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec = n_vec + 1;
    if (out_vld !== 1'b0 || net_out !== 16'd0 || stable !== 1'b0 ||
        overload !== 1'b0 || under_tare !== 1'b0) begin
      n_bad = n_bad + 1;
      $display("FAIL reset_state: got vld=%0b net=%0d st=%0b ov=%0b ut=%0b, required all 0",
               out_vld, net_out, stable, overload, under_tare);
    end else begin
      $display("reset ok");
    end
    rst = 1'b0;
  endtask

  task automatic pulse_tare();
    @(posedge clk);
    #1 tare_req = 1'b1;
    @(posedge clk);
    #1 tare_req = 1'b0;
  endtask

  // One sample; if exp_vld the listed output is expected two cycles later.
  // tare_s2 raises tare_req exactly on this sample's S2 edge.
  task automatic send(input logic [15:0] v, input bit exp_vld, input logic [15:0] en,
                      input bit es, input bit eo, input bit eu, input bit tare_s2);
    exp_t e;
    int   out_before;
    vec_id = vec_id + 1;
    if (exp_vld) begin
      e.id = vec_id; e.net = en; e.st = es; e.ov = eo; e.ut = eu;
      exp_q.push_back(e);
    end
    out_before = n_out;
    @(posedge clk);
    #1 hx_in = v; hx_vld = 1'b1;
    @(posedge clk);
    #1 hx_vld = 1'b0; tare_req = tare_s2;
    @(posedge clk);
    #1 tare_req = 1'b0;
    @(posedge clk);
    #1;
    n_vec = n_vec + 1;
    if ((n_out - out_before) != (exp_vld ? 1 : 0)) begin
      n_bad = n_bad + 1;
      $display("FAIL vec%0d_count: got %0d out_vld pulses, required %0d",
               vec_id, n_out - out_before, exp_vld ? 1 : 0);
    end
  endtask

  initial begin
    rst = 1'b1; hx_in = '0; hx_vld = 1'b0; tare_req = 1'b0;
    do_reset();

    // Fill then ramp
    for (int i = 0; i < 3; i++) send(100, 0, 0, 0, 0, 0, 0);
    send(100, 1, 100, 0, 0, 0, 0);
    send(200, 1, 125, 0, 0, 0, 0);
    send(200, 1, 150, 0, 0, 0, 0);
    send(200, 1, 175, 0, 0, 0, 0);
    send(200, 1, 200, 0, 0, 0, 0);

    // Settling, tolerance boundary, then loss of stability
    do_reset();
    for (int i = 0; i < 3; i++) send(100, 0, 0, 0, 0, 0, 0);
    send(100, 1, 100, 0, 0, 0, 0);
    send(100, 1, 100, 0, 0, 0, 0);
    send(100, 1, 100, 0, 0, 0, 0);
    send(100, 1, 100, 1, 0, 0, 0);
    send(110, 1, 102, 1, 0, 0, 0);
    send(120, 1, 107, 0, 0, 0, 0);

    // Tare and under-tare clamp
    do_reset();
    for (int i = 0; i < 3; i++) send(100, 0, 0, 0, 0, 0, 0);
    send(100, 1, 100, 0, 0, 0, 0);
    pulse_tare();
    send(100, 1, 0, 0, 0, 0, 0);
    send(140, 1, 10, 0, 0, 0, 0);
    send(140, 1, 20, 0, 0, 0, 0);
    send(140, 1, 30, 0, 0, 0, 0);
    send(140, 1, 40, 0, 0, 0, 0);
    send(60, 1, 20, 0, 0, 0, 0);
    send(60, 1, 0, 0, 0, 0, 0);
    send(60, 1, 0, 0, 0, 1, 0);
    send(60, 1, 0, 0, 0, 1, 0);

    // Mid-operation reset clears tare and window
    send(70, 1, 0, 0, 0, 1, 0);
    send(70, 1, 0, 0, 0, 1, 0);
    do_reset();
    send(70, 0, 0, 0, 0, 0, 0);
    send(70, 0, 0, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) send(50, 0, 0, 0, 0, 0, 0);
    send(50, 1, 50, 0, 0, 0, 0);

    // Tare requested during fill, and tare coinciding with an S2 edge
    do_reset();
    pulse_tare();
    for (int i = 0; i < 3; i++) send(80, 0, 0, 0, 0, 0, 0);
    send(80, 1, 0, 0, 0, 0, 0);
    send(84, 1, 1, 0, 0, 0, 0);
    send(84, 1, 2, 0, 0, 0, 1);
    send(84, 1, 0, 0, 0, 0, 0);
    send(88, 1, 2, 0, 0, 0, 0);

    // Overload, including net exactly at the limit
    do_reset();
    for (int i = 0; i < 3; i++) send(1200, 0, 0, 0, 0, 0, 0);
    send(1200, 1, 1200, 0, 1, 0, 0);
    send(900, 1, 1125, 0, 1, 0, 0);
    send(900, 1, 1050, 0, 1, 0, 0);
    send(900, 1, 975, 0, 0, 0, 0);
    send(900, 1, 900, 0, 0, 0, 0);
    send(1300, 1, 1000, 0, 0, 0, 0);
    send(1304, 1, 1101, 0, 1, 0, 0);

    repeat (5) @(posedge clk);
    #1;
    n_vec = n_vec + 1;
    if (exp_q.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL drain: got %0d outputs still outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
